// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue:
// step/reset defaults, FSM encoding and counter sizing.
package fetch_pkg;

    localparam int          DEF_PC_STEP  = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    // Counters must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs.
// Flush empties it in one cycle; no read bypass.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic [W-1:0]              head,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch PC owner: issues in-order imem reads, buffers
// returned words with their PCs, supports redirect/flush.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int                PC_STEP  = DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready
);

    localparam int                CW     = cnt_w(DEPTH);
    localparam int                QW     = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(PC_STEP);
    localparam logic [CW+1:0]     CREDIT = (CW+2)'(DEPTH);

    fetch_state_e      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [ADDR_W-1:0] new_pc;
    logic [CW-1:0]     count;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;
    logic [CW+1:0]     in_use;
    logic [QW-1:0]     head;
    logic              req_fire;
    logic              rsp_push;
    logic              rsp_drop;
    logic              out_fire;

    // Stale responses still occupy memory slots, so they
    // count against credit; this also bounds discard.
    assign in_use = (CW+2)'(count) + (CW+2)'(outstanding)
                  + (CW+2)'(discard);

    assign imem_req_valid = !reset && (state == FETCH)
                         && !redirect_valid && (in_use < CREDIT);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_drop = imem_rsp_valid & (discard != '0);
    assign rsp_push = imem_rsp_valid & (discard == '0)
                    & !redirect_valid;

    assign out_valid = !reset && (count != '0);
    assign out_fire  = out_valid & out_ready;
    assign {out_pc, out_instr} = head;

    assign new_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            // A presented request stays up until accepted.
            if (imem_req_valid && !imem_req_ready)
                state <= FETCH;
            else
                state <= fetch_en ? FETCH : IDLE;

            if (redirect_valid) begin
                fetch_pc    <= new_pc;
                rsp_pc      <= new_pc;
                outstanding <= '0;
                discard     <= discard + outstanding
                             - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + STEP;
                if (rsp_push) rsp_pc   <= rsp_pc + STEP;
                if (rsp_drop) discard  <= discard - 1'b1;
                outstanding <= outstanding + CW'(req_fire)
                             - CW'(rsp_push);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (QW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (out_fire),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised + directed bench for instr_fetch_queue against
// an in-order stream model and a latency memory model.
module tb_instr_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RST   = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b1;

    instr_fetch_queue #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RST),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    int          fires = 0;
    int          reqs = 0;
    int          inflight = 0;
    logic [31:0] exp_pc = RST;
    logic [31:0] exp_req = RST;
    logic        hold_v = 1'b0;
    logic [31:0] hold_a = '0;
    logic        was_redir = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        if (!reset && mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        if (reset) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_req_valid", imem_req_valid, 0);
            mq.delete();
            exp_pc    = RST;
            exp_req   = RST;
            inflight  = 0;
            hold_v    = 1'b0;
            was_redir = 1'b0;
        end else begin
            if (was_redir)
                chk("post_redir_out_valid", out_valid, 0);
            if (hold_v && !redirect_valid) begin
                chk("req_hold_valid", imem_req_valid, 1);
                chk("req_hold_addr", imem_req_addr, hold_a);
            end
            if (redirect_valid)
                chk("redir_req_valid", imem_req_valid, 0);
            if (out_valid && out_ready) begin
                chk("out_pc", out_pc, exp_pc);
                chk("out_instr", out_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                inflight--;
                fires++;
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_req);
                exp_req = exp_req + 32'd4;
                mq.push_back('{imem_req_addr, cyc + lat});
                inflight++;
                reqs++;
                chk("credit", inflight <= DEPTH, 1);
            end
            hold_v    = imem_req_valid && !imem_req_ready;
            hold_a    = imem_req_addr;
            was_redir = redirect_valid;
            if (redirect_valid) begin
                exp_pc   = {redirect_pc[31:2], 2'b00};
                exp_req  = exp_pc;
                inflight = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int f0;
        int r0;
        bit hit;

        @(posedge clk);
        #1;

        // 1: streaming from reset, latency 1
        fetch_en = 1'b1;
        lat = 1;
        do_reset();
        chk("t1_idle_req", imem_req_valid, 0);
        chk("t1_idle_out", out_valid, 0);
        f0 = fires;
        repeat (20) tick();
        chk("t1_progress", (fires - f0) >= 10, 1);

        // 2: backpressure fills exactly DEPTH credits
        out_ready = 1'b0;
        do_reset();
        r0 = reqs;
        repeat (15) tick();
        chk("t2_req_count", reqs - r0, DEPTH);
        chk("t2_req_stalled", imem_req_valid, 0);
        out_ready = 1'b1;
        repeat (10) tick();
        chk("t2_resumed", reqs - r0 > DEPTH, 1);

        // 3: redirect with two reads in flight, latency 3
        lat = 3;
        do_reset();
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (mq.size() == 2) hit = 1;
            else tick();
        end
        chk("t3_reach_inflight", hit, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        f0 = fires;
        repeat (25) tick();
        chk("t3_progress", (fires - f0) >= 3, 1);

        // 4: redirect coincident with response and out fire
        lat = 1;
        do_reset();
        repeat (4) tick();
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (out_valid && mq.size() != 0 && mq[0].due <= cyc)
                hit = 1;
            else tick();
        end
        chk("t4_reach", hit, 1);
        f0 = fires;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("t4_fire_once", fires - f0, 1);
        #1;
        chk("t4_req_valid_r1", imem_req_valid, 1);
        chk("t4_req_addr_r1", imem_req_addr, 32'h0000_0200);
        repeat (10) tick();

        // 6: reset while queue holds words and reads in flight
        lat = 3;
        out_ready = 1'b0;
        do_reset();
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (out_valid && mq.size() == 2) hit = 1;
            else tick();
        end
        chk("t6_reach", hit, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        chk("t6_out_valid", out_valid, 0);
        hit = 0;
        for (int i = 0; i < 5 && !hit; i++) begin
            if (imem_req_valid) hit = 1;
            else tick();
        end
        chk("t6_req_seen", hit, 1);
        chk("t6_req_addr", imem_req_addr, RST);
        repeat (10) tick();

        // random traffic
        fetch_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) fetch_en = ~fetch_en;
            out_ready      = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = $urandom_range(0, 1) ? $urandom
                           : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            lat = $urandom_range(1, 4);
            tick();
        end
        reset = 1'b0;
        redirect_valid = 1'b0;

        // drain: every requested word must come out
        fetch_en = 1'b0;
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        repeat (40) tick();
        chk("drain_inflight", inflight, 0);
        chk("drain_out_valid", out_valid, 0);
        chk("drain_req_valid", imem_req_valid, 0);
        chk("drain_mem_idle", mq.size(), 0);
        chk("total_progress", fires > 500, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
